// File: rtl/mem_pkg.sv
// Shared constants and response payload for the main-memory model and its fill-path clients.
package mem_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned LATENCY     = 4;
  localparam int unsigned WORD_BYTES  = 2;
  localparam int unsigned WORD_ADDR_W = ADDR_W - $clog2(WORD_BYTES);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_delay_line.sv
// DEPTH-stage response shift register; clear drops every valid bit and zeroes the output word.
// The final stage only takes new data on a valid slot, so the output word holds between responses.
module mem_delay_line
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      i_clr,
  input  mem_resp_t i_resp,
  output mem_resp_t o_resp
);

  mem_resp_t r_stage [DEPTH];
  mem_resp_t w_in    [DEPTH];

  always_comb begin
    w_in[0] = i_resp;
    for (int i = 1; i < DEPTH; i++) begin
      w_in[i] = r_stage[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i].valid <= 1'b0;
      end
      r_stage[DEPTH-1].data <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_stage[i] <= w_in[i];
      end
      r_stage[DEPTH-1].valid <= w_in[DEPTH-1].valid;
      if (w_in[DEPTH-1].valid) begin
        r_stage[DEPTH-1].data <= w_in[DEPTH-1].data;
      end
    end
  end

  assign o_resp = r_stage[DEPTH-1];

endmodule

// File: rtl/multicycle_memory.sv
// Single-port word memory with a fixed-latency, fully pipelined read path and write-through stores.
// Optional misaligned-address flag `err` is built only when MEM_ALIGN_CHECK_EN is defined.
module multicycle_memory #(
  parameter int unsigned ADDR_W  = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W  = mem_pkg::DATA_W,
  parameter int unsigned LATENCY = mem_pkg::LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  import mem_pkg::*;

  localparam int unsigned WORD_IDX_W = ADDR_W - 1;
  localparam int unsigned NUM_WORDS  = 1 << WORD_IDX_W;
  localparam int unsigned RESP_DW    = $bits(mem_resp_t) - 1;

  logic [DATA_W-1:0]     r_mem [NUM_WORDS];
  logic [WORD_IDX_W-1:0] w_word_idx;
  logic                  w_wr_req;
  logic                  w_rd_req;
  mem_resp_t             w_rd_resp;
  mem_resp_t             w_out_resp;

  // Requests coinciding with reset are dropped, writes included.
  assign w_word_idx = addr[ADDR_W-1:1];
  assign w_wr_req   = enable & wr & ~rst;
  assign w_rd_req   = enable & ~wr & ~rst;

  always_ff @(posedge clk) begin
    if (w_wr_req) begin
      r_mem[w_word_idx] <= data_in;
    end
  end

  // Read samples the array at issue; stage 0 of the delay line captures it.
  always_comb begin
    w_rd_resp       = '0;
    w_rd_resp.valid = w_rd_req;
    w_rd_resp.data  = RESP_DW'(r_mem[w_word_idx]);
  end

  mem_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay_line (
    .clk    (clk),
    .i_clr  (rst),
    .i_resp (w_rd_resp),
    .o_resp (w_out_resp)
  );

  assign data_out   = DATA_W'(w_out_resp.data);
  assign data_valid = w_out_resp.valid;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= enable & addr[0];
    end
  end

  assign err = r_err;
`else
  logic w_unused_addr0;
  assign w_unused_addr0 = addr[0];
`endif

endmodule

// File: tb/tb_multicycle_memory.sv
// Bench for multicycle_memory: fixed vector table, random traffic against a queue-based model,
// and hand sequences for mid-flight reset and misaligned access (err checked if MEM_ALIGN_CHECK_EN).
module tb_multicycle_memory;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
`ifdef MEM_ALIGN_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  multicycle_memory #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .err        (err)
`endif
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } pend_t;

  vec_t        tbl[$];
  pend_t       pend[$];
  logic [15:0] model_mem [int];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_out = '0;
  bit          last_known = 1'b0;
  bit          err_exp = 1'b0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour: each read is due LAT cycles after the cycle it is presented in.
  task automatic model_edge(input logic r, input logic en, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
    pend_t p;
    int    idx;
    idx = int'(a >> 1);
    if (r) begin
      pend.delete();
      last_out   = '0;
      last_known = 1'b1;
      err_exp    = 1'b0;
    end else begin
      if (en && !w) begin
        p.due   = cyc + LAT;
        p.known = model_mem.exists(idx);
        p.data  = p.known ? model_mem[idx] : 16'h0;
        pend.push_back(p);
      end
      if (en && w) model_mem[idx] = d;
      err_exp = en & a[0];
    end
  endtask

  task automatic model_check();
    pend_t p;
    bit    exp_v;
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    cmp("model_valid", {15'b0, data_valid}, {15'b0, exp_v});
    if (exp_v) begin
      p          = pend.pop_front();
      last_out   = p.data;
      last_known = p.known;
    end
    if (last_known) cmp("model_data", data_out, last_out);
`ifdef MEM_ALIGN_CHECK_EN
    cmp("model_err", {15'b0, err}, {15'b0, err_exp});
`endif
  endtask

  task automatic cycle(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    model_edge(r, en, w, a, d);
    cyc++;
    #1;
    model_check();
  endtask

  task automatic add(input logic r, input logic en, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic ev, input logic [15:0] ed);
    vec_t v;
    v.rst = r; v.en = en; v.wr = w; v.addr = a; v.din = d; v.exp_v = ev; v.exp_d = ed;
    tbl.push_back(v);
  endtask

  initial begin
    // Reset held two cycles with reads presented, then quiet.
    add(1, 1, 0, 16'h0010, 0, 0, 16'h0000);
    add(1, 1, 0, 16'h0010, 0, 0, 16'h0000);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 16'h0000);
    // Write then read the same word.
    add(0, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000);
    add(0, 1, 0, 16'h0010, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 1, 16'hBEEF);
    add(0, 0, 0, 0, 0, 0, 16'hBEEF);
    // Block fill burst.
    for (int i = 0; i < 8; i++)
      add(0, 1, 1, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i), 0, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 16'(16'h0100 + 2 * i), 0, (i >= 3), (i >= 3) ? 16'(16'h1000 + i - 3) : 16'hBEEF);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 16'(16'h1005 + i));
    add(0, 0, 0, 0, 0, 0, 16'h1007);
    // Read/write hazard on word 0x0020.
    add(0, 1, 1, 16'h0020, 16'h1111, 0, 16'h1007);
    add(0, 1, 0, 16'h0020, 0, 0, 16'h1007);
    add(0, 1, 1, 16'h0020, 16'h2222, 0, 16'h1007);
    add(0, 1, 0, 16'h0020, 0, 0, 16'h1007);
    add(0, 0, 0, 0, 0, 1, 16'h1111);
    add(0, 0, 0, 0, 0, 0, 16'h1111);
    add(0, 0, 0, 0, 0, 1, 16'h2222);
    add(0, 0, 0, 0, 0, 0, 16'h2222);
    // Reads in flight killed by reset.
    add(0, 1, 0, 16'h0020, 0, 0, 16'h2222);
    add(0, 1, 0, 16'h0010, 0, 0, 16'h2222);
    add(0, 1, 0, 16'h0100, 0, 0, 16'h2222);
    add(1, 1, 0, 16'h0102, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 16'h0000);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din);
      cmp($sformatf("tbl%0d_valid", i), {15'b0, data_valid}, {15'b0, tbl[i].exp_v});
      cmp($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_d);
    end

    // Misaligned read still returns the addressed word.
    cycle(0, 1, 1, 16'h0030, 16'hABCD);
    cycle(0, 1, 0, 16'h0031, 0);
`ifdef MEM_ALIGN_CHECK_EN
    cmp("align_err_pulse", {15'b0, err}, 16'h0001);
`endif
    cycle(0, 0, 0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    cmp("align_err_clear", {15'b0, err}, 16'h0000);
`endif
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cmp("align_valid", {15'b0, data_valid}, 16'h0001);
    cmp("align_data", data_out, 16'hABCD);

    // Random traffic over a small word pool to exercise hazards.
    for (int i = 0; i < 16; i++)
      cycle(0, 1, 1, 16'(16'h4000 + 2 * i), 16'($urandom));
    for (int i = 0; i < 1500; i++) begin
      logic        r, en, w;
      logic [15:0] a;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = 16'(16'h4000 + 2 * $urandom_range(0, 15) + $urandom_range(0, 1));
      cycle(r, en, w, a, 16'($urandom));
    end
    for (int i = 0; i < LAT + 2; i++) cycle(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_memory.md
# multicycle_memory

Main-memory model feeding the cache fill path: a 64 KB, 16-bit-word, single-port memory with fixed 4-cycle read latency and fully pipelined requests. Sits directly downstream of the cache fill FSM's `memory_address` output and upstream of its `memory_data` / `memory_data_valid` inputs. It also absorbs write-through stores from the cache. It accepts one request per cycle and never stalls.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width (64 KB space)
- `DATA_W`, 16, word width (2-byte transfer granularity)
- `LATENCY`, 4, cycles from read issue to `data_valid`; legal range 1..8

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `enable`  in  1  request strobe; one request per cycle when high
- `wr`  in  1  qualifies `enable`: 1 = write, 0 = read
- `addr`  in  ADDR_W  byte address; word index = `addr[ADDR_W-1:1]`; `addr[0]` ignored
- `data_in`  in  DATA_W  write data
- `data_out`  out  DATA_W  read data; meaningful only while `data_valid`
- `data_valid`  out  1  high for exactly one cycle per completed read
- `err`  out  1  misaligned-access flag; present only with `MEM_ALIGN_CHECK_EN`

## Operation
- Storage: 2^(ADDR_W-1) words. Contents are not cleared by `rst`, and the power-up contents are undefined.
- Write (`enable & wr`): the word is updated at the issuing clock edge. There is no response and `data_valid` is not asserted.
- Read (`enable & ~wr`): the array is sampled at the issuing edge. The sampled word and a valid bit enter a LATENCY-deep delay line, and the word appears on `data_out` with `data_valid` LATENCY cycles later.
- Ordering: responses return strictly in issue order. Back-to-back reads produce back-to-back valids with no bubbles.
- Read/write hazard: a write issued after a read never alters that read's returned data, because the read sampled the array at issue. A read issued in the cycle after a write to the same word returns the new value.
- `enable` low: the delay line shifts in an invalid slot.
- `data_out` holds its last valid value while `data_valid` is low. Consumers must not rely on that value.

## Timing
- Read issued at edge N: `data_valid` is high in the cycle following edge N+LATENCY-1. For LATENCY=4, a request at cycle 0 gives valid during cycle 4.
- Throughput: 1 request/cycle, sustained indefinitely. No backpressure.
- Reset values: `data_out`=0, `data_valid`=0, `err`=0, and all delay-line valid bits cleared.
- Reset mid-operation: all in-flight reads are discarded and no `data_valid` follows. A request presented in the same cycle as `rst` is ignored, including writes.
- First request is accepted on the first edge with `rst` low.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - `err` is registered high for one cycle after any request with `addr[0]=1`.
  - The request is still performed on the word index.
  - `err` is not pipelined with read data and is cleared by `rst`.
- Not defined: the `err` port and its logic are absent, and `addr[0]` is silently ignored.

## Structure
- Package `mem_pkg` holds:
  - `ADDR_W`, `DATA_W`, `LATENCY` defaults, and `WORD_BYTES`=2.
  - The derived `WORD_ADDR_W` = ADDR_W-1.
  - A `mem_resp_t` typedef containing `{valid, data}`.
- The fill FSM imports the same constants for address sequencing.
- Sub-module `mem_delay_line`: a parameterised LATENCY-stage shift register of `mem_resp_t` with synchronous active-high clear of the valid bits. The top level instantiates it once after the array read port.

## Test plan
- Reset check: hold `rst` for 2 cycles with reads issued → `data_valid`=0, `data_out`=0, and no valid appears in the following 6 cycles.
- Single read/write:
  - Write 0xBEEF to 0x0010, then read 0x0010 on the next cycle.
  - Required: exactly one valid, 4 cycles after the read issue, carrying 0xBEEF.
- Block fill burst:
  - Preload 0x0100..0x010E with 0x1000..0x1007, then issue 8 consecutive reads at cycles 0..7.
  - Required: valids in cycles 4..11 returning 0x1000..0x1007 in order, with no gaps.
- Hazard:
  - Word 0x0020 holds 0x1111; read it at cycle 0, then write 0x2222 at cycle 1.
  - Required: cycle-4 response is 0x1111, and a re-read at cycle 2 returns 0x2222 at cycle 6.
- Mid-flight reset: issue reads at cycles 0..2 and assert `rst` at cycle 3 → no `data_valid` at cycles 4..6.
- Alignment (`MEM_ALIGN_CHECK_EN` defined):
  - Write 0xABCD to 0x0030, then read `addr`=0x0031.
  - Required: `err` pulses one cycle after the read issue, and the response is 0xABCD.
  - With the macro undefined: same response, and no `err` port.
